// File: rtl/prog_loader.sv
// Switch-and-button program loader: debounces two keys and writes one word per
// press into instruction memory, then freezes the program for the CPU to run.
module prog_loader #(
    parameter int ADDR_W     = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_wr,
    input  logic              key_run,
    input  logic [15:0]       sw_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_we,
    output logic              run,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              ovf,
    output logic [31:0]       disp
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Index 0 = write key, index 1 = run key.
    logic [1:0]         s1_q, s2_q, lvl_q, lvl_d, arm_q;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         ev;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              pend_q, pend_d;
    logic [31:0]       disp_q, disp_d;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            lvl_d[k] = lvl_q[k];
            cnt_d[k] = '0;
            if (s2_q[k] != lvl_q[k]) begin
                if (cnt_q[k] == CW'(DEB_CYCLES - 1)) lvl_d[k] = s2_q[k];
                else cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end
    end

    // A key only arms once it has been seen released after reset.
    assign ev = arm_q & lvl_q & ~lvl_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q  <= 2'b00;
            s2_q  <= 2'b00;
            lvl_q <= 2'b11;
            cnt_q <= '0;
            arm_q <= 2'b00;
        end else begin
            s1_q  <= {key_run, key_wr};
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
            arm_q <= arm_q | s2_q;
        end
    end

    assign full = count_q[ADDR_W];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        unique case (state_q)
            LOAD: begin
                if (ev[1] || pend_q) begin
                    pend_d = 1'b0;
                    if (count_q != '0) state_d = RUN;
                end else if (ev[0]) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        data_d  = sw_data;
                        addr_d  = count_q[ADDR_W-1:0];
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                count_d = count_q + 1'b1;
                state_d = LOAD;
                if (ev[1]) pend_d = 1'b1;
            end
            RUN: begin
                if (ev[1]) begin
                    state_d = LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
        disp_d = {state_d == RUN, 3'b000, 12'(count_d), data_d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
        end
    end

    assign mem_we   = (state_q == WRITE);
    assign run      = (state_q == RUN);
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign disp     = disp_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with DEB_CYCLES=4, ADDR_W=2.
module tb_prog_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          key_wr, key_run;
    logic [15:0]   sw_data;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_we;
    logic          run;
    logic [AW:0]   count;
    logic          full;
    logic          ovf;
    logic [31:0]   disp;

    int            n_chk = 0;
    int            n_pass = 0;
    int            we_cnt = 0;
    int            we0;
    logic [AW-1:0] last_addr;
    logic [15:0]   last_data;

    prog_loader #(.ADDR_W(AW), .DEB_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .key_wr(key_wr), .key_run(key_run),
        .sw_data(sw_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .run(run), .count(count), .full(full),
        .ovf(ovf), .disp(disp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_cnt++;
            last_addr = mem_addr;
            last_data = mem_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_wr(input logic [15:0] d);
        sw_data = d;
        key_wr = 1'b0;
        cyc(10);
        key_wr = 1'b1;
        cyc(10);
    endtask

    task automatic press_run();
        key_run = 1'b0;
        cyc(10);
        key_run = 1'b1;
        cyc(10);
    endtask

    initial begin
        logic seen;
        logic [15:0] vals [5];
        vals = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5};
        key_wr = 1'b1;
        key_run = 1'b1;
        sw_data = 16'h0;
        reset = 1'b0;
        #1;
        chk("rst_we", {31'b0, mem_we}, 0);
        chk("rst_addr", {30'b0, mem_addr}, 0);
        chk("rst_data", {16'b0, mem_data}, 0);
        chk("rst_cnt", {29'b0, count}, 0);
        chk("rst_flags", {29'b0, run, full, ovf}, 0);
        chk("rst_disp", disp, 0);
        cyc(2);
        reset = 1'b1;
        cyc(10);

        press_wr(16'h1234);
        chk("w1_we", we_cnt, 1);
        chk("w1_addr", {30'b0, last_addr}, 0);
        chk("w1_data", {16'b0, last_data}, 32'h1234);
        chk("w1_cnt", {29'b0, count}, 1);
        chk("w1_disp", disp, 32'h0001_1234);

        sw_data = 16'h5678;
        for (int i = 0; i < 10; i++) begin
            key_wr = ~key_wr;
            cyc(2);
        end
        key_wr = 1'b0;
        cyc(10);
        key_wr = 1'b1;
        cyc(10);
        chk("bounce_we", we_cnt, 2);
        chk("bounce_addr", {30'b0, last_addr}, 1);
        chk("bounce_cnt", {29'b0, count}, 2);

        we0 = we_cnt;
        key_wr = 1'b0;
        key_run = 1'b0;
        cyc(10);
        key_wr = 1'b1;
        key_run = 1'b1;
        cyc(10);
        chk("both_run", {31'b0, run}, 1);
        chk("both_we", we_cnt - we0, 0);
        chk("both_cnt", {29'b0, count}, 2);
        chk("both_disp", disp, 32'h8002_5678);

        press_wr(16'hDEAD);
        chk("runwr_we", we_cnt - we0, 0);
        chk("runwr_ovf", {31'b0, ovf}, 0);
        press_run();
        chk("clr_run", {31'b0, run}, 0);
        chk("clr_cnt", {29'b0, count}, 0);
        press_run();
        chk("run0_run", {31'b0, run}, 0);

        for (int i = 0; i < 5; i++) begin
            we0 = we_cnt;
            press_wr(vals[i]);
            if (i < 4) begin
                chk("fill_we", we_cnt - we0, 1);
                chk("fill_addr", {30'b0, last_addr}, i);
                chk("fill_data", {16'b0, last_data}, {16'b0, vals[i]});
            end else begin
                chk("full_we", we_cnt - we0, 0);
            end
        end
        chk("full_cnt", {29'b0, count}, 4);
        chk("full_flag", {31'b0, full}, 1);
        chk("full_ovf", {31'b0, ovf}, 1);
        press_run();
        chk("full_run", {31'b0, run}, 1);
        press_run();
        chk("clr2_ovf", {31'b0, ovf}, 0);
        chk("clr2_full", {31'b0, full}, 0);
        chk("clr2_cnt", {29'b0, count}, 0);

        we0 = we_cnt;
        sw_data = 16'hBEEF;
        key_wr = 1'b0;
        cyc(1);
        key_run = 1'b0;
        cyc(10);
        key_wr = 1'b1;
        key_run = 1'b1;
        cyc(10);
        chk("defer_we", we_cnt - we0, 1);
        chk("defer_run", {31'b0, run}, 1);
        chk("defer_disp", disp, 32'h8001_BEEF);
        press_run();
        chk("defer_clr", {29'b0, count}, 0);

        we0 = we_cnt;
        sw_data = 16'h4321;
        key_wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = mem_we;
        end
        chk("rst_seen_we", {31'b0, seen}, 1);
        reset = 1'b0;
        #1;
        chk("mid_we", {31'b0, mem_we}, 0);
        chk("mid_cnt", {29'b0, count}, 0);
        chk("mid_out", {mem_addr, mem_data}, 0);
        chk("mid_disp", disp, 0);
        cyc(2);
        reset = 1'b1;
        cyc(20);
        chk("held_we", we_cnt - we0, 0);
        chk("held_cnt", {29'b0, count}, 0);
        key_wr = 1'b1;
        cyc(10);
        press_wr(16'h7777);
        chk("after_we", we_cnt - we0, 1);
        chk("after_data", {16'b0, last_data}, 32'h7777);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter DEB_CYCLES, default 16, meaning consecutive stable samples required to accept a key level.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_wr  input  1  raw push-button "write word", active-low, asynchronous to clk.
REQ-006 SHALL have port key_run  input  1  raw push-button "run/clear", active-low, asynchronous to clk.
REQ-007 SHALL have port sw_data  input  16  instruction word from switches, quasi-static.
REQ-008 SHALL have port mem_addr  output  ADDR_W  instruction-memory write address.
REQ-009 SHALL have port mem_data  output  16  instruction-memory write data.
REQ-010 SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 SHALL have port run  output  1  level; high = program frozen, CPU may fetch.
REQ-012 SHALL have port count  output  ADDR_W+1  number of words loaded, 0..2^ADDR_W.
REQ-013 SHALL have port full  output  1  high when count == 2^ADDR_W.
REQ-014 SHALL have port ovf  output  1  sticky: write press rejected because full.
REQ-015 SHALL have port disp  output  32  HEX display word.

Function
REQ-016 SHALL pass each key through a 2-flop synchronizer before debouncing.
REQ-017 SHALL, per key, keep a debounced level; it changes only after DEB_CYCLES consecutive synchronized samples differ from it (counter restarts on any matching sample).
REQ-018 SHALL generate a one-cycle press event on debounced 1->0 transition only; release and held key produce no further events.
REQ-019 SHALL implement FSM states LOAD, WRITE, RUN.
REQ-020 LOAD: write event and !full -> latch sw_data into mem_data, mem_addr = count[ADDR_W-1:0], go WRITE.
REQ-021 WRITE: mem_we = 1 for exactly this cycle; at its end count increments; return to LOAD.
REQ-022 LOAD: write event while full -> no write, ovf set, state unchanged.
REQ-023 LOAD: run event with count > 0 -> RUN (run = 1 next cycle); with count == 0 -> ignored.
REQ-024 RUN: write events ignored (no mem_we, ovf unchanged).
REQ-025 RUN: run event -> LOAD with count = 0, ovf = 0, run = 0 next cycle; memory contents not cleared.
REQ-026 Simultaneous write and run events in LOAD: run wins, write dropped.
REQ-027 Event arriving during WRITE: run event deferred and taken in the following LOAD cycle; write event dropped.
REQ-028 mem_we SHALL never be high outside WRITE; mem_addr/mem_data SHALL hold their values outside WRITE.
REQ-029 count SHALL saturate at 2^ADDR_W; never wraps.
REQ-030 disp SHALL equal {run, 3'b0, count zero-extended to 12 bits, mem_data} ({1,3,12,16} bits), registered.
REQ-031 Latency: key held low from cycle 0 -> event at cycle 2+DEB_CYCLES (±1), mem_we the following cycle.

Reset
REQ-032 On reset low, asynchronously: state LOAD, count 0, full 0, ovf 0, run 0, mem_we 0, mem_addr 0, mem_data 0, disp 0, debounced levels 1 (released), debounce counters 0.
REQ-033 Reset asserted mid-WRITE SHALL abort the write (mem_we low immediately); count not incremented.
REQ-034 Release of reset SHALL produce no spurious press events even if a key is held low.

Verification (DEB_CYCLES=4, ADDR_W=2)
REQ-035 sw_data=16'h1234, key_wr pressed 10 cycles -> exactly one mem_we with addr 0, data 16'h1234; count=1; disp=32'h0001_1234.
REQ-036 key_wr toggling every 2 cycles for 20 cycles (bounce) then low -> exactly one mem_we.
REQ-037 Five presses with data A1..A5 -> writes to addr 0..3 with A1..A4; fifth rejected; full=1, ovf=1, count=4.
REQ-038 key_run with count=0 -> run stays 0; after one write, key_run -> run=1, disp[31]=1; key_wr -> no mem_we; key_run again -> run=0, count=0, ovf=0.
REQ-039 Both keys pressed same cycle in LOAD with count=2 -> run=1, no mem_we, count=2.
REQ-040 reset asserted during WRITE -> mem_we drops same cycle, all outputs at reset values; key_wr held through deassertion -> no write.
